spi_frame_tx: RTL and testbench

SPI slave transmitter producing the 40-bit frames consumed by the board's SPI frame receiver. It accepts a frame from local logic over a valid/ready handshake, holds it in a one-entry buffer, and shifts it out MSB-first on `miso` while the master holds `ss_n` low. It sits on the servo-command source side, in the same `clk` domain as its producer. `sclk` and `ss_n` are asynchronous pins and are synchronized internally.

---
 rtl/spi_pkg.sv | 15 +
 rtl/sync_edge.sv | 40 ++++
 rtl/spi_frame_tx.sv | 183 ++++++++++++++++++
 tb/tb_spi_frame_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI frame definitions.
// Contents:
//   SPI_FRAME_BITS - bits per SPI frame; the frame receiver uses the same constant
//   spi_tx_state_t - transmitter FSM states
package spi_pkg;

    localparam int unsigned SPI_FRAME_BITS = 40;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } spi_tx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with registered edge pulses.
// Ports:
//   clk, rst - system clock, synchronous active-high reset
//   din      - asynchronous input pin
//   rise     - one-cycle pulse, synchronized rising edge of din
//   fall     - one-cycle pulse, synchronized falling edge of din
// The pulse register compares the last two synchronizer stages, so an edge on din
// appears on rise/fall SYNC_STAGES clk cycles after the pin change.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rise_q;
    logic                   fall_q;

    // Chain resets to 0: a spurious rise after reset is harmless because rises are
    // only acted on mid-frame, and a low pin at reset release is not taken as a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            rise_q <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
            fall_q <= ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/spi_frame_tx.sv
// SPI slave frame transmitter (CPOL=0/CPHA=0), MSB first.
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   sclk, ss_n  - asynchronous SPI clock and active-low select from the master
//   miso        - serial data to master; miso_oe enables the pad while selected
//   tx_data/tx_valid/tx_ready - frame input handshake into a one-entry hold buffer
//   frame_done  - pulse, full frame shifted out
//   underrun    - pulse, frame started with nothing buffered (previous frame repeated)
//   aborted     - pulse, ss_n released mid-frame
module spi_frame_tx
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_BITS  = SPI_FRAME_BITS,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  ss_n,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  frame_done,
    output logic                  underrun,
    output logic                  aborted
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ss_n),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    spi_tx_state_t         state_q, state_d;
    // Bits still to send after the one currently on miso.
    logic [FRAME_BITS-2:0] sr_q, sr_d;
    logic [FRAME_BITS-1:0] last_q, last_d;
    logic [FRAME_BITS-1:0] hold_q, hold_d;
    logic [FRAME_BITS-1:0] load_frame;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  hold_full_q, hold_full_d;
    logic                  tx_ready_q;
    logic                  miso_q, miso_d;
    logic                  oe_q, oe_d;
    logic                  done_q, done_d;
    logic                  under_q, under_d;
    logic                  abort_q, abort_d;
    logic                  load_hold, bypass, accept;

    assign accept = tx_valid & tx_ready_q;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        done_d     = 1'b0;
        under_d    = 1'b0;
        abort_d    = 1'b0;
        load_hold  = 1'b0;
        bypass     = 1'b0;
        load_frame = last_q;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                oe_d   = 1'b0;
                if (ss_fall) begin
                    if (hold_full_q) begin
                        load_frame = hold_q;
                        load_hold  = 1'b1;
                    end else if (accept) begin
                        load_frame = tx_data;
                        bypass     = 1'b1;
                    end else begin
                        under_d    = 1'b1;
                    end
                    sr_d    = load_frame[FRAME_BITS-2:0];
                    miso_d  = load_frame[FRAME_BITS-1];
                    last_d  = load_frame;
                    cnt_d   = '0;
                    oe_d    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    abort_d = 1'b1;
                    miso_d  = 1'b0;
                    oe_d    = 1'b0;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        done_d  = 1'b1;
                        miso_d  = 1'b0;
                        state_d = DONE;
                    end
                end else if (sclk_fall && cnt_q != '0) begin
                    // Only shift once the master has sampled the current bit.
                    miso_d = sr_q[FRAME_BITS-2];
                    sr_d   = {sr_q[FRAME_BITS-3:0], 1'b0};
                end
            end
            DONE: begin
                miso_d = 1'b0;
                if (ss_rise) begin
                    oe_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bypass consumes the handshake directly, so it must not also fill the buffer.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        if (load_hold) begin
            hold_full_d = 1'b0;
        end else if (accept && !bypass) begin
            hold_full_d = 1'b1;
            hold_d      = tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            last_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_ready_q  <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            done_q      <= 1'b0;
            under_q     <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_ready_q  <= !hold_full_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            done_q      <= done_d;
            under_q     <= under_d;
            abort_q     <= abort_d;
        end
    end

    assign miso       = miso_q;
    assign miso_oe    = oe_q;
    assign tx_ready   = tx_ready_q;
    assign frame_done = done_q;
    assign underrun   = under_q;
    assign aborted    = abort_q;

endmodule

// File: tb/tb_spi_frame_tx.sv
// Self-checking bench for spi_frame_tx: directed scenarios plus randomized transfers
// checked against a frame-level model (buffer queue + last-frame memory).
module tb_spi_frame_tx;

    localparam int unsigned FB   = 40;
    localparam int unsigned SYNC = 2;
    localparam int          HALF = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sclk = 1'b0;
    logic          ss_n = 1'b1;
    logic          miso, miso_oe, tx_ready, frame_done, underrun, aborted;
    logic [FB-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;

    spi_frame_tx #(.FRAME_BITS(FB), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .ss_n       (ss_n),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .frame_done (frame_done),
        .underrun   (underrun),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_done = 0, n_under = 0, n_abort = 0;
    int done_cyc = 0;

    // Reference model: frames waiting in the buffer and the last frame sent.
    logic [FB-1:0] model_q[$];
    logic [FB-1:0] last_frame = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clk cycle; outputs sampled on the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (frame_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (underrun) n_under++;
        if (aborted)  n_abort++;
    endtask

    function automatic logic [FB-1:0] rand_frame();
        logic [FB-1:0] r;
        r[31:0]  = $urandom();
        r[39:32] = 8'($urandom());
        return r;
    endfunction

    task automatic push(input logic [FB-1:0] d);
        int t = 0;
        while (!tx_ready && t < 200) begin
            step();
            t++;
        end
        check("push_wait", 64'(t < 200), 64'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        model_q.push_back(d);
        check("push_ready_low", 64'(tx_ready), 64'd0);
    endtask

    // One master transaction of 'rises' sclk periods. Optionally offers a bypass frame
    // in the cycle the select fall is recognized, pushes a frame mid-transfer, or
    // asserts rst at rise index rst_at.
    task automatic transfer(input string tag, input int rises, input bit byp,
                            input logic [FB-1:0] byp_data, input bit mid,
                            input logic [FB-1:0] mid_data, input int rst_at);
        int            d0 = n_done, u0 = n_under, a0 = n_abort;
        int            rise_cyc = 0;
        int            sh;
        bit            exp_under;
        logic [FB-1:0] exp;
        logic [FB-1:0] got = '0;

        if (model_q.size() != 0) begin
            exp = model_q.pop_front();
            exp_under = 1'b0;
        end else if (byp) begin
            exp = byp_data;
            exp_under = 1'b0;
        end else begin
            exp = last_frame;
            exp_under = 1'b1;
        end
        last_frame = exp;

        ss_n = 1'b0;
        step();
        step();
        if (byp) begin
            tx_data  = byp_data;
            tx_valid = 1'b1;
        end
        step();
        tx_valid = 1'b0;
        repeat (3) step();
        check({tag, "_oe_on"}, 64'(miso_oe), 64'd1);

        for (int i = 0; i < rises; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                step();
                check({tag, "_rst_out"}, 64'({miso, miso_oe, tx_ready, frame_done,
                                             underrun, aborted}), 64'd0);
                step();
                rst = 1'b0;
                model_q.delete();
                last_frame = '0;
                step();
                check({tag, "_rst_ready"}, 64'(tx_ready), 64'd1);
                sclk = 1'b0;
                ss_n = 1'b1;
                repeat (8) step();
                check({tag, "_rst_idle"}, 64'({miso, miso_oe}), 64'd0);
                return;
            end
            sclk = 1'b1;
            got[FB-1-i] = miso;
            rise_cyc = cyc;
            if (mid && i == 10) begin
                check({tag, "_mid_ready"}, 64'(tx_ready), 64'd1);
                tx_data  = mid_data;
                tx_valid = 1'b1;
                step();
                tx_valid = 1'b0;
                model_q.push_back(mid_data);
                repeat (HALF - 1) step();
                check({tag, "_mid_ready_low"}, 64'(tx_ready), 64'd0);
            end else begin
                repeat (HALF) step();
            end
            sclk = 1'b0;
            repeat (HALF) step();
        end

        sh = FB - rises;
        check({tag, "_bits"}, 64'(got >> sh), 64'(exp >> sh));
        if (rises == FB) begin
            check({tag, "_done_lat"}, 64'(done_cyc - rise_cyc), 64'(SYNC + 1));
            check({tag, "_miso_idle"}, 64'(miso), 64'd0);
        end
        check({tag, "_done_cnt"}, 64'(n_done - d0), 64'(rises == FB));
        ss_n = 1'b1;
        repeat (6) step();
        check({tag, "_abort_cnt"}, 64'(n_abort - a0), 64'(rises < FB));
        check({tag, "_under_cnt"}, 64'(n_under - u0), 64'(exp_under));
        check({tag, "_off"}, 64'({miso, miso_oe}), 64'd0);
        check({tag, "_ready"}, 64'(tx_ready), 64'(model_q.size() == 0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [FB-1:0] f;
        rst = 1'b1;
        repeat (3) step();
        check("rst_ready", 64'(tx_ready), 64'd0);
        check("rst_out", 64'({miso, miso_oe, frame_done, underrun, aborted}), 64'd0);
        rst = 1'b0;
        step();
        check("post_rst_ready", 64'(tx_ready), 64'd1);
        repeat (4) step();

        // Basic frame, then a repeat with nothing buffered.
        push(40'hA5_1234_5678);
        transfer("t1", 40, 1'b0, '0, 1'b0, '0, -1);
        transfer("t2_underrun", 40, 1'b0, '0, 1'b0, '0, -1);

        // Bypass with an empty buffer; then the bypassed frame repeats on underrun.
        transfer("t3_bypass", 40, 1'b1, 40'h00_0000_0001, 1'b0, '0, -1);
        transfer("t3_repeat", 40, 1'b0, '0, 1'b0, '0, -1);

        // Abort after 17 rises; a frame pushed mid-way goes out next, not the remainder.
        push(40'h3C_DEAD_BEEF);
        transfer("t4_abort", 17, 1'b0, '0, 1'b1, 40'h96_0F0F_1234, -1);
        transfer("t4_next", 40, 1'b0, '0, 1'b0, '0, -1);

        // Frame B pushed during frame A.
        push(40'h12_3456_789A);
        transfer("t5_a", 40, 1'b0, '0, 1'b1, 40'hFE_DCBA_9876, -1);
        transfer("t5_b", 40, 1'b0, '0, 1'b0, '0, -1);

        // Reset mid-frame drops buffered data; next transfer underruns with zero.
        push(40'h55_AAAA_5555);
        transfer("t6_rst", 40, 1'b0, '0, 1'b1, 40'h77_1111_2222, 20);
        transfer("t6_after", 40, 1'b0, '0, 1'b0, '0, -1);

        for (int k = 0; k < 8; k++) begin
            int  r;
            int  rises;
            bit  mid;
            bit  byp;
            r     = int'($urandom_range(0, 3));
            byp   = (r == 1);
            mid   = (r == 2);
            rises = ($urandom_range(0, 4) == 0) ? int'($urandom_range(11, 39)) : 40;
            if (r == 0 && model_q.size() == 0) begin
                f = rand_frame();
                push(f);
            end
            transfer($sformatf("rnd%0d", k), rises, byp, rand_frame(), mid, rand_frame(), -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
